// File: rtl/mem_access_unit_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the multicycle-CPU memory port:
//   - access size encodings (SZ_WORD / SZ_HALF / SZ_BYTE; 2'b11 behaves as word)
//   - memory-port FSM state encoding
//   - default request timeout (used only when MEM_TIMEOUT_EN is defined)
//   - latched access control record and the alignment rule
// ----------------------------------------------------------------------------
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Access control captured on start; size/we already normalised for fetches.
    typedef struct packed {
        logic       iord;
        logic       we;
        logic [1:0] size;
        logic       sext;
    } acc_ctl_t;

    // Half needs addr[0]=0, word (and the 2'b11 alias) needs addr[1:0]=00.
    function automatic logic lane_misaligned(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: lane_misaligned = 1'b0;
            SZ_HALF: lane_misaligned = addr_lo[0];
            default: lane_misaligned = |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ----------------------------------------------------------------------------
// mem_lane_align
// Combinational little-endian byte-lane steering for a 32-bit memory bus.
// Ports:
//   size       in  2   access size (SZ_* encoding, 2'b11 = word)
//   addr_lo    in  2   byte offset within the word
//   sext       in  1   sign-extend sub-word loads
//   wdata      in  32  store data, low-aligned
//   rdata      in  32  bus read data
//   be         out 4   byte enables
//   wdata_lane out 32  store data replicated across lanes
//   rdata_ext  out 32  selected load lane, zero/sign extended
//   misaligned out 1   access violates the alignment rule
// ----------------------------------------------------------------------------
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte    = rdata[{addr_lo, 3'b000} +: 8];
        rd_half    = rdata[{addr_lo[1], 4'b0000} +: 16];
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        misaligned = lane_misaligned(size, addr_lo);
        case (size)
            SZ_BYTE: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{sext & rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{sext & rd_half[15]}}, rd_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// Memory port of a multicycle CPU: runs IF / MEM accesses against a
// variable-latency memory, holds IR and MDR, steers byte lanes.
// Optional feature macro: MEM_TIMEOUT_EN (REQ timeout -> bus_err).
// Ports:
//   clk, rst (async, active low)
//   start/iord/we/size/sext/addr/wdata  access request from control
//   busy, done, align_err, bus_err      status to control
//   ir, mdr                             instruction / memory data registers
//   m_req/m_we/m_addr/m_be/m_wdata      bus request (registered, held in REQ)
//   m_rdata/m_ack                       bus response
// ----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              iord,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              align_err,
    output logic              bus_err,
    output logic [31:0]       ir,
    output logic [31:0]       mdr,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_be,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    input  logic              m_ack
);

    state_t     state;
    acc_ctl_t   ctl;
    acc_ctl_t   in_ctl;
    logic [1:0] addr_lo;
    logic       tmo;

    logic [1:0]  la_size;
    logic [1:0]  la_addr_lo;
    logic        la_sext;
    logic [3:0]  la_be;
    logic [31:0] la_wdata;
    logic [31:0] la_rdata;
    logic        la_mis;

    // Fetches are always word reads regardless of size/we.
    always_comb begin
        in_ctl      = '0;
        in_ctl.iord = iord;
        in_ctl.we   = iord & we;
        in_ctl.size = iord ? size : SZ_WORD;
        in_ctl.sext = sext;
    end

    // One aligner serves both phases: in IDLE it evaluates the incoming
    // request (alignment, lanes to register), afterwards the latched access
    // (load extraction on m_ack).
    always_comb begin
        if (state == ST_IDLE) begin
            la_size    = in_ctl.size;
            la_addr_lo = addr[1:0];
            la_sext    = in_ctl.sext;
        end else begin
            la_size    = ctl.size;
            la_addr_lo = addr_lo;
            la_sext    = ctl.sext;
        end
    end

    mem_lane_align u_align (
        .size       (la_size),
        .addr_lo    (la_addr_lo),
        .sext       (la_sext),
        .wdata      (wdata),
        .rdata      (m_rdata),
        .be         (la_be),
        .wdata_lane (la_wdata),
        .rdata_ext  (la_rdata),
        .misaligned (la_mis)
    );

    assign busy = (state != ST_IDLE);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] tcnt;

    // tcnt counts REQ cycles already spent without ack; the current cycle
    // is the last allowed one when it reaches TIMEOUT_CYCLES-1.
    assign tmo = (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt    <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= (state == ST_REQ) && !m_ack && tmo;
            if (state != ST_REQ)
                tcnt <= '0;
            else if (!m_ack)
                tcnt <= tcnt + 1'b1;
        end
    end
`else
    assign tmo     = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ctl       <= '0;
            addr_lo   <= '0;
            done      <= 1'b0;
            align_err <= 1'b0;
            ir        <= '0;
            mdr       <= '0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_be      <= '0;
            m_wdata   <= '0;
        end else begin
            done      <= 1'b0;
            align_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ctl     <= in_ctl;
                        addr_lo <= addr[1:0];
                        if (la_mis) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            align_err <= 1'b1;
                        end else begin
                            state   <= ST_REQ;
                            m_req   <= 1'b1;
                            m_we    <= in_ctl.we;
                            m_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            m_be    <= la_be;
                            m_wdata <= la_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack has priority over a coincident timeout.
                    if (m_ack || tmo) begin
                        if (m_ack) begin
                            if (!ctl.iord)
                                ir <= m_rdata;
                            else if (!ctl.we)
                                mdr <= la_rdata;
                        end
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        m_req   <= 1'b0;
                        m_we    <= 1'b0;
                        m_addr  <= '0;
                        m_be    <= '0;
                        m_wdata <= '0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
